// File: rtl/lc3_io_pkg.sv
// lc3_io_pkg: shared types and constants for the LC-3 serial display path.
package lc3_io_pkg;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_ddr_if.sv
// uart_tx_ddr_if: send/data handshake and serial output between display controller and transmitter.
interface uart_tx_ddr_if;
  logic send;
  logic [15:0] ddr;
  logic tx;
  logic busy;
  logic done;
  modport master (output send, ddr, input tx, busy, done);
  modport slave (input send, ddr, output tx, busy, done);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter; tick is high in the last cycle of each bit, clr holds the count at zero.
module uart_baud_tick
  import lc3_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = !clr && cnt_q == LAST;
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_ddr.sv
// uart_tx_ddr: 8N1 transmitter for the DDR low byte; UART_TX_PARITY_EN adds an even parity bit (8E1).
module uart_tx_ddr
  import lc3_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input logic clk,
  input logic rst,
  uart_tx_ddr_if.slave bus
);
  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t AFTER_DATA = S_PARITY;
`else
  localparam uart_tx_state_t AFTER_DATA = S_STOP;
`endif
  uart_tx_state_t state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic tick, accept, shift, unused_ddr_hi;
  assign accept = state_q == S_IDLE && bus.send;
  assign shift = state_q == S_DATA && tick;
  assign unused_ddr_hi = ^bus.ddr[15:8];
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == S_IDLE || state_q == S_DONE),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.send ? S_START : S_IDLE;
      S_START:  state_d = tick ? S_DATA : S_START;
      S_DATA:   state_d = (tick && idx_q == LAST_IDX) ? AFTER_DATA : S_DATA;
`ifdef UART_TX_PARITY_EN
      S_PARITY: state_d = tick ? S_STOP : S_PARITY;
`endif
      S_STOP:   state_d = tick ? S_DONE : S_STOP;
      default:  state_d = S_IDLE;
    endcase
  end
  // outputs are computed from the next state so tx/busy/done come straight from flops
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d = accept ? ^bus.ddr[7:0] : par_q;
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
  always_comb begin
    sh_d = accept ? bus.ddr[7:0] : shift ? {1'b0, sh_q[7:1]} : sh_q;
    idx_d = accept ? 3'd0 : shift ? idx_q + 3'd1 : idx_q;
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : state_d == S_PARITY ? par_q : 1'b1;
`else
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : 1'b1;
`endif
    busy_d = state_d != S_IDLE && state_d != S_DONE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      idx_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.tx = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_uart_tx_ddr.sv
// tb_uart_tx_ddr: scoreboard bench; stimulus pushes expected frames, a monitor checks tx/busy/done against them.
module tb_uart_tx_ddr;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DN = NB * CPB + 1;
  typedef struct {
    logic [10:0] f;
    int start;
  } exp_t;
  exp_t q[$];
  logic clk, rst;
  int cyc, checks, errors, done_cnt;
  logic dsr;
  uart_tx_ddr_if bif ();
  uart_tx_ddr #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bif));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial done_cnt = 0;
  always @(negedge clk) if (bif.done === 1'b1) done_cnt++;
  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic logic [10:0] mk(logic [7:0] d, logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b1, 1'b1 | p, d, 1'b0};
`endif
  endfunction
  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic pulse_send(logic [15:0] d, bit push, logic p, int start);
    exp_t e;
    bif.send = 1'b1;
    bif.ddr = d;
    if (push) begin
      e.f = mk(d[7:0], p);
      e.start = start;
      q.push_back(e);
    end
    @(negedge clk);
    bif.send = 1'b0;
  endtask
  initial begin : mon
    exp_t e;
    bit ab;
    forever begin
      @(negedge clk);
      #1;
      if (rst || bif.tx !== 1'b0) continue;
      if (q.size() == 0) begin
        chk("unexpected_frame", 32'(q.size()), 1);
        continue;
      end
      e = q.pop_front();
      chk("start_cycle", 32'(cyc), 32'(e.start));
      ab = 0;
      for (int i = 0; i < NB * CPB; i++) begin
        if (i > 0) begin
          @(negedge clk);
          #1;
        end
        if (rst) begin
          ab = 1;
          break;
        end
        chk("tx_bit", {31'd0, bif.tx}, {31'd0, e.f[i/CPB]});
        chk("busy_in_frame", {31'd0, bif.busy}, 1);
      end
      if (!ab) begin
        @(negedge clk);
        #1;
        chk("done_pulse", {31'd0, bif.done}, 1);
        chk("busy_at_done", {31'd0, bif.busy}, 0);
        chk("tx_at_done", {31'd0, bif.tx}, 1);
        @(negedge clk);
        #1;
        chk("done_one_cycle", {31'd0, bif.done}, 0);
        chk("tx_idle", {31'd0, bif.tx}, 1);
      end
    end
  end
  initial begin
    int base, n, t, dc;
    logic [7:0] hs_chars[3];
    checks = 0;
    errors = 0;
    rst = 1;
    bif.send = 0;
    bif.ddr = '0;
    dsr = 1;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, bif.tx}, 1);
    chk("rst_busy", {31'd0, bif.busy}, 0);
    chk("rst_done", {31'd0, bif.done}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    // single byte 0x41
    base = cyc;
    pulse_send(16'h0041, 1, 1'b0, base + 1);
    wait_to(base + DN + 3);
    // upper byte ignored, mid-frame ddr change ignored
    base = cyc;
    pulse_send(16'hFF55, 1, 1'b0, base + 1);
    wait_to(base + 10);
    bif.ddr = 16'h00AA;
    wait_to(base + DN + 3);
    // reset mid-frame aborts without done
    base = cyc;
    pulse_send(16'h005A, 1, 1'b0, base + 1);
    wait_to(base + 15);
    n = done_cnt;
    rst = 1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, bif.tx}, 1);
    chk("midrst_busy", {31'd0, bif.busy}, 0);
    chk("midrst_done", {31'd0, bif.done}, 0);
    @(negedge clk);
    rst = 0;
    wait_to(cyc + 60);
    chk("no_done_after_rst", 32'(done_cnt), 32'(n));
    chk("idle_after_rst", {31'd0, bif.tx}, 1);
    // busy rejection, DONE-cycle rejection, earliest restart
    base = cyc;
    pulse_send(16'h00A5, 1, 1'b0, base + 1);
    wait_to(base + 5);
    pulse_send(16'h0033, 0, 1'b0, 0);
    wait_to(base + 20);
    pulse_send(16'h0033, 0, 1'b0, 0);
    wait_to(base + DN);
    pulse_send(16'h0033, 0, 1'b0, 0);
    pulse_send(16'h003C, 1, 1'b0, base + DN + 2);
    wait_to(base + 2 * DN + 4);
    // display controller handshake over 3 characters
    hs_chars = '{8'h48, 8'h69, 8'h21};
    for (int k = 0; k < 3; k++) begin
      chk("hs_dsr_ready", {31'd0, dsr}, 1);
      base = cyc;
      n = done_cnt;
      pulse_send({8'h00, hs_chars[k]}, 1, 1'b0, base + 1);
      dsr = 0;
      t = 0;
      while (bif.done !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("hs_done_timeout", 32'(t), 0);
      dc = cyc;
      chk("hs_done_cycle", 32'(dc), 32'(base + DN));
      wait_to(dc + 2);
      dsr = 1;
      chk("hs_one_done", 32'(done_cnt), 32'(n + 1));
      wait_to(cyc + 3);
    end
    // parity vector: 0x07 has odd weight, so even parity bit is 1
    base = cyc;
    pulse_send(16'h0007, 1, 1'b1, base + 1);
    wait_to(base + DN + 3);
    wait_to(cyc + 10);
    chk("queue_empty", 32'(q.size()), 0);
    chk("total_done", 32'(done_cnt), 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_ddr.md
# uart_tx_ddr

Serial transmitter for the LC-3 display path, directly downstream of the display output controller. It accepts a one-cycle `send` strobe together with the display data register (DDR) value, and shifts the low byte out on `tx` as an asynchronous 8N1 frame. When the stop bit completes it returns a one-cycle `done` pulse, which lets the controller reload DSR. The block owns all baud timing, so the controller only sequences the handshake.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `send`  input  1  start strobe. Sampled every cycle; acted on only when idle.
- `ddr`  input  16  display data register. Only `ddr[7:0]` is transmitted; `ddr[15:8]` is ignored.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high from the cycle after an accepted `send` until the cycle `done` pulses.
- `done`  output  1  one-cycle pulse marking frame completion.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (present only with the parity macro)
  - STOP
  - DONE
- IDLE:
  - `tx`=1, `busy`=0.
  - `send`=1 latches `ddr[7:0]` into the shift register, clears the bit counter and baud counter, and moves to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA:
  - `tx` = shift register bit 0, LSB first.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the 3-bit index.
  - After bit 7, go to PARITY (if enabled) or STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then DONE.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - `tx`=1.
  - Next state is IDLE unconditionally.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - It counts 0 to `CLKS_PER_BIT-1`; the bit-end tick fires at `CLKS_PER_BIT-1`, and the counter then wraps to 0.
- `send` while not IDLE is ignored. The latched byte is unaffected, and `ddr` changes mid-frame have no effect.
- `send` in the DONE cycle is ignored. A new frame is accepted no earlier than the following IDLE cycle.
- Reset:
  - Values: `tx`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
  - Reset mid-frame aborts the frame with no `done` pulse. `tx` returns high on the cycle after `rst` is sampled.

## Timing
- `send` is sampled at edge 0.
- START is driven during cycles 1..CPB, where CPB = `CLKS_PER_BIT`.
- Data bit k occupies cycles (k+1)·CPB+1 .. (k+2)·CPB.
- The stop bit ends at cycle 10·CPB. `done` is high in cycle 10·CPB+1. With parity the frame is one bit longer: `done` is high in cycle 11·CPB+1.
- Earliest next `send` acceptance is cycle 10·CPB+2. Back-to-back frames therefore have exactly 2 idle-high cycles between stop bit and start bit.
- `tx` is a registered output with no combinational path from `send` or `ddr`.
- `done` is a registered pulse. It is compatible with a consumer that waits on `done` at any level of its own handshake state.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - `tx` = even parity (XOR of the latched 8 bits), held for CPB cycles.
  - Frame is 8E1, 11 bits.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame is 8N1, 10 bits.

## Structure
- Shared package `lc3_io_pkg`:
  - state enum `uart_tx_state_t`
  - `UART_DEFAULT_CLKS_PER_BIT` = 868
  - `UART_DATA_BITS` = 8
- Sub-module `uart_baud_tick`:
  - Parameter `CLKS_PER_BIT`.
  - Inputs `clk`, `rst`, `clr`; output `tick`.
  - `clr` restarts the count. `tick` is high in the last cycle of each bit period.
  - The FSM, shift register and bit index stay in `uart_tx_ddr`.

## Test plan
All cases use `CLKS_PER_BIT`=4 unless stated.
- Reset: assert `rst` for 2 cycles mid-frame → `tx`=1, `busy`=0, `done`=0 on the next cycle. No `done` pulse follows.
- Single byte: `send` with `ddr`=16'h0041 at cycle 0 → `tx` frame 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles long, spanning cycles 1–40. `done`=1 only at cycle 41.
- Upper byte ignored and mid-frame changes: `ddr`=16'hFF55, then `ddr` changed to 16'h00AA at cycle 10 → transmitted data bits are 0x55 (1,0,1,0,1,0,1,0).
- Busy rejection: second `send` at cycles 5, 20 and 41 (DONE) → only one frame is emitted and only one `done`. A `send` at cycle 42 starts a new start bit at cycle 43.
- Handshake with display controller: DSR=1 → controller strobes `send` → exactly one `done` → controller pulses `ld_dsr_ext` 2 cycles later. Verified over 3 consecutive characters.
- Parity (`UART_TX_PARITY_EN`, CPB=4): `ddr`=16'h0007 → parity bit=1 during cycles 37–40, stop bit during 41–44, `done` at cycle 45.
